// File: rtl/cla_multiword_adder_seq_if.sv
// Bus between a requester and the multi-word sequential CLA adder.
// start_in is a request sampled only while the adder is idle; done_out is a one-cycle result strobe.
interface cla_multiword_adder_seq_if #(
    parameter int NUMBITS  = 4,
    parameter int NUMWORDS = 4
);
    localparam int WIDTH = NUMBITS * NUMWORDS;

    logic             start_in;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             c_in;
    logic             busy_out;
    logic             done_out;
    logic [WIDTH-1:0] s_out;
    logic             c_out;
    logic [1:0]       dbg_state;

    modport master (
        output start_in, a_in, b_in, c_in,
        input  busy_out, done_out, s_out, c_out, dbg_state
    );

    modport slave (
        input  start_in, a_in, b_in, c_in,
        output busy_out, done_out, s_out, c_out, dbg_state
    );
endinterface

// File: rtl/cla_multiword_adder_seq.sv
// Wide adder that streams NUMWORDS slices of NUMBITS bits through a single
// carry-lookahead slice, LS slice first, with a registered inter-slice carry.
module cla_multiword_adder_seq #(
    parameter int NUMBITS  = 4,
    parameter int NUMWORDS = 4
) (
    input  logic clk,
    input  logic rst_n,
    cla_multiword_adder_seq_if.slave io_bus
);
    localparam int              WIDTH    = NUMBITS * NUMWORDS;
    localparam int              IDXW     = (NUMWORDS > 1) ? $clog2(NUMWORDS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUMWORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // One NUMBITS-wide lookahead slice: every carry is a flat sum of
    // generate terms gated by propagate runs, returned as {carry, sum}.
    function automatic logic [NUMBITS:0] cla_slice(
        input logic [NUMBITS-1:0] a,
        input logic [NUMBITS-1:0] b,
        input logic               ci
    );
        logic [NUMBITS-1:0] p;
        logic [NUMBITS-1:0] g;
        logic [NUMBITS:0]   c;
        logic               acc;
        logic               run;
        p    = a ^ b;
        g    = a & b;
        c    = '0;
        c[0] = ci;
        for (int k = 0; k < NUMBITS; k++) begin
            acc = 1'b0;
            run = 1'b1;
            for (int j = k; j >= 0; j--) begin
                acc = acc | (run & g[j]);
                run = run & p[j];
            end
            c[k+1] = acc | (run & ci);
        end
        return {c[NUMBITS], p ^ c[NUMBITS-1:0]};
    endfunction

    state_t                           r_state;
    state_t                           w_next;
    logic [NUMWORDS-1:0][NUMBITS-1:0] r_a;
    logic [NUMWORDS-1:0][NUMBITS-1:0] r_b;
    logic [NUMWORDS-1:0][NUMBITS-1:0] r_part;
    logic [NUMWORDS-1:0][NUMBITS-1:0] w_full;
    logic                             r_carry;
    logic [IDXW-1:0]                  r_idx;
    logic [WIDTH-1:0]                 r_s;
    logic                             r_c;
    logic [NUMBITS:0]                 w_slice;
    logic                             w_last;

    assign w_slice = cla_slice(r_a[r_idx], r_b[r_idx], r_carry);
    assign w_last  = (r_idx == LAST_IDX);

    // Completed sum: stored lower slices plus the slice being added this cycle.
    always_comb begin
        w_full        = r_part;
        w_full[r_idx] = w_slice[NUMBITS-1:0];
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (io_bus.start_in) w_next = ST_RUN;
            ST_RUN:  if (w_last) w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_part  <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_s     <= '0;
            r_c     <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_IDLE: begin
                    if (io_bus.start_in) begin
                        r_a     <= io_bus.a_in;
                        r_b     <= io_bus.b_in;
                        r_carry <= io_bus.c_in;
                        r_idx   <= '0;
                    end
                end
                ST_RUN: begin
                    r_part[r_idx] <= w_slice[NUMBITS-1:0];
                    r_carry       <= w_slice[NUMBITS];
                    if (w_last) begin
                        r_idx <= '0;
                        r_s   <= w_full;
                        r_c   <= w_slice[NUMBITS];
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign io_bus.busy_out  = (r_state == ST_RUN);
    assign io_bus.done_out  = (r_state == ST_DONE);
    assign io_bus.s_out     = r_s;
    assign io_bus.c_out     = r_c;
    assign io_bus.dbg_state = r_state;
endmodule
